// File: rtl/re_pkg.sv
// Shared types and constants for the uplink RE mapper slot path.
// Holds the scheduler state encoding and the slot allocation struct.
package re_pkg;

  localparam int MAX_SC       = 1200;
  localparam int SC_PER_RB    = 12;
  localparam int SYM_PER_SLOT = 14;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_MAP_WAIT,
    S_DRAIN,
    S_DONE
  } sched_state_t;

  typedef struct packed {
    logic [3:0]  sym_start;
    logic [3:0]  sym_end;
    logic [10:0] n_sc;
    logic [6:0]  n_rb;
  } re_cfg_t;

  // Allocation must fit inside the slot and the subcarrier grid.
  function automatic logic cfg_err(input re_cfg_t c);
    logic [10:0] rb_sc;
    logic [11:0] sum;
    rb_sc = 11'(11'(c.n_rb) * 11'(SC_PER_RB));
    sum   = 12'(c.n_sc) + 12'(rb_sc);
    return (c.sym_end < c.sym_start)
        || (c.sym_end > 4'(SYM_PER_SLOT - 1))
        || (c.n_rb == 7'd0)
        || (sum > 12'(MAX_SC));
  endfunction

endpackage

// File: rtl/pingpong_tracker.sv
// Two-buffer symbol grid occupancy: mapper fills one buffer while
// the IFFT drains the other.
module pingpong_tracker
  import re_pkg::*;
(
  input  logic       CLK_RE,
  input  logic       RST_RE,
  input  logic       clr,
  input  logic       set,
  input  logic [3:0] set_idx,
  input  logic       ifft_ack,
  output logic       wr_free,
  output logic       wr_ptr,
  output logic       buf_empty,
  output logic       ifft_req,
  output logic       ifft_buf_sel,
  output logic [3:0] ifft_sym_idx
);

  logic [1:0] buf_full;
  logic       rd_ptr;
  logic [3:0] sym_idx [2];

  always_ff @(posedge CLK_RE or negedge RST_RE) begin
    if (!RST_RE) begin
      buf_full   <= 2'b00;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      sym_idx[0] <= 4'd0;
      sym_idx[1] <= 4'd0;
    end else if (clr) begin
      buf_full <= 2'b00;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
    end else begin
      // set and ack always target different buffers
      if (set) begin
        buf_full[wr_ptr] <= 1'b1;
        sym_idx[wr_ptr]  <= set_idx;
        wr_ptr           <= ~wr_ptr;
      end
      if (ifft_ack && buf_full[rd_ptr]) begin
        buf_full[rd_ptr] <= 1'b0;
        rd_ptr           <= ~rd_ptr;
      end
    end
  end

  assign wr_free      = ~buf_full[wr_ptr];
  assign buf_empty    = (buf_full == 2'b00);
  assign ifft_req     = buf_full[rd_ptr];
  assign ifft_buf_sel = rd_ptr;
  assign ifft_sym_idx = sym_idx[rd_ptr];

endmodule

// File: rtl/re_slot_scheduler.sv
// Slot sequencer for the uplink RE mapper: DMRS first, then data
// symbols, through a ping-pong grid feeding the IFFT.
module re_slot_scheduler
  import re_pkg::*;
#(
  parameter int TIMEOUT_CYC = 4095
) (
  input  logic        CLK_RE,
  input  logic        RST_RE,
  input  logic        slot_start,
  input  logic [3:0]  cfg_sym_start,
  input  logic [3:0]  cfg_sym_end,
  input  logic [10:0] cfg_n_sc,
  input  logic [6:0]  cfg_n_rb,
  output logic [3:0]  map_sym_start,
  output logic [3:0]  map_sym_end,
  output logic [10:0] map_n_sc,
  output logic [6:0]  map_n_rb,
  output logic        dmrs_start,
  output logic        fft_start,
  output logic [3:0]  map_sym_idx,
  output logic        map_buf_sel,
  input  logic        map_sym_done,
  output logic        ifft_req,
  output logic        ifft_buf_sel,
  output logic [3:0]  ifft_sym_idx,
  input  logic        ifft_ack,
  output logic        busy,
  output logic        slot_done,
  output logic        slot_err
);

  localparam int WDW = $clog2(TIMEOUT_CYC + 1);

  sched_state_t   state;
  re_cfg_t        cfg;
  logic [3:0]     sym_idx;
  logic [WDW-1:0] wd;
  logic           err_flag;
  logic           wr_free;
  logic           buf_empty;
  logic           map_set;
  logic           wd_exp;
  logic           abort;

  assign map_set = (state == S_MAP_WAIT) && map_sym_done;
  assign wd_exp  = (state == S_MAP_WAIT) && !map_sym_done
                && (wd == '0);
  assign abort   = ((state == S_CHECK) && cfg_err(cfg)) || wd_exp;

  assign map_sym_start = cfg.sym_start;
  assign map_sym_end   = cfg.sym_end;
  assign map_n_sc      = cfg.n_sc;
  assign map_n_rb      = cfg.n_rb;
  assign map_sym_idx   = sym_idx;

  pingpong_tracker u_pp (
    .CLK_RE       (CLK_RE),
    .RST_RE       (RST_RE),
    .clr          (abort),
    .set          (map_set),
    .set_idx      (sym_idx),
    .ifft_ack     (ifft_ack),
    .wr_free      (wr_free),
    .wr_ptr       (map_buf_sel),
    .buf_empty    (buf_empty),
    .ifft_req     (ifft_req),
    .ifft_buf_sel (ifft_buf_sel),
    .ifft_sym_idx (ifft_sym_idx)
  );

  always_ff @(posedge CLK_RE or negedge RST_RE) begin
    if (!RST_RE) begin
      state      <= S_IDLE;
      cfg        <= '0;
      sym_idx    <= 4'd0;
      wd         <= '0;
      err_flag   <= 1'b0;
      dmrs_start <= 1'b0;
      fft_start  <= 1'b0;
      busy       <= 1'b0;
      slot_done  <= 1'b0;
      slot_err   <= 1'b0;
    end else begin
      dmrs_start <= 1'b0;
      fft_start  <= 1'b0;
      slot_done  <= 1'b0;
      slot_err   <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (slot_start) begin
            cfg.sym_start <= cfg_sym_start;
            cfg.sym_end   <= cfg_sym_end;
            cfg.n_sc      <= cfg_n_sc;
            cfg.n_rb      <= cfg_n_rb;
            err_flag      <= 1'b0;
            busy          <= 1'b1;
            state         <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (cfg_err(cfg)) begin
            err_flag <= 1'b1;
            state    <= S_DONE;
          end else begin
            sym_idx <= cfg.sym_start;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (wr_free) begin
            if (sym_idx == cfg.sym_start) dmrs_start <= 1'b1;
            else                          fft_start  <= 1'b1;
            wd    <= WDW'(TIMEOUT_CYC);
            state <= S_MAP_WAIT;
          end
        end
        S_MAP_WAIT: begin
          if (map_sym_done) begin
            if (sym_idx == cfg.sym_end) begin
              state <= S_DRAIN;
            end else begin
              sym_idx <= sym_idx + 4'd1;
              state   <= S_ISSUE;
            end
          end else if (wd == '0) begin
            err_flag <= 1'b1;
            state    <= S_DONE;
          end else begin
            wd <= wd - 1'b1;
          end
        end
        S_DRAIN: begin
          if (buf_empty) state <= S_DONE;
        end
        S_DONE: begin
          slot_done <= 1'b1;
          slot_err  <= err_flag;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
